// File: rtl/card_blitter.sv
// card_blitter
//   Copies one card image (CARD_W x CARD_H pixels held in a 512 x 3-bit sprite memory with a
//   registered read) into the 256x240 frame buffer at a latched (X,Y) position, row-major.
//   Pixels that land off-screen are clipped (read still issued, write suppressed), so a blit
//   always takes the same number of cycles.
//
//   Optional feature macro: TRANSPARENT_EN
//     defined   - pixels with colour 0 are not written (background shows through).
//     undefined - colour 0 is written like any other colour.
//
// Ports
//   i_clock      system clock, posedge
//   i_reset      asynchronous active-high reset, returns to idle
//   i_start      blit request, sampled only while idle
//   i_card_x/y   card top-left screen position, latched on an accepted start
//   o_busy       high from the first read cycle until the done cycle inclusive
//   o_done       one-cycle completion pulse
//   o_card_re    card memory read strobe
//   o_card_addr  card memory read address (row*CARD_W + col)
//   i_card_data  card memory read data, one cycle after o_card_addr
//   o_fb_we      frame buffer write enable
//   o_fb_addr    frame buffer write address (y*SCREEN_W + x)
//   o_fb_data    frame buffer write data
module card_blitter #(
  parameter int unsigned CardW   = 16,
  parameter int unsigned CardH   = 32,
  parameter int unsigned ScreenW = 256,
  parameter int unsigned ScreenH = 240,
  parameter int unsigned ColorW  = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_card_x,
  input  logic [7:0]        i_card_y,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_card_re,
  output logic [8:0]        o_card_addr,
  input  logic [ColorW-1:0] i_card_data,
  output logic              o_fb_we,
  output logic [15:0]       o_fb_addr,
  output logic [ColorW-1:0] o_fb_data
);

  localparam int unsigned AddrW = $clog2(CardW * CardH);
  localparam int unsigned ColW  = $clog2(CardW);
  localparam int unsigned RowW  = AddrW - ColW;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [7:0]         r_x, r_y;
  logic [AddrW-1:0]   r_cnt;      // address being issued this cycle
  logic [AddrW-1:0]   r_pix;      // address issued last cycle, aligned with i_card_data
  logic               r_wr_vld;   // write stage holds a pixel this cycle

  logic [ColW-1:0]    w_col;
  logic [RowW-1:0]    w_row;
  logic [8:0]         w_x_sum, w_y_sum;
  logic               w_clip;
  logic               w_skip;
  logic [15:0]        w_fb_addr;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRead;
      StRead:  if (r_cnt == AddrW'(CardW * CardH - 1)) w_state_next = StDrain;
      StDrain: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Position latch, read counter and write-stage pipeline register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_pix    <= '0;
      r_wr_vld <= 1'b0;
    end else begin
      r_wr_vld <= (r_state == StRead);
      r_pix    <= r_cnt;
      if (r_state == StIdle && i_start) begin
        r_x   <= i_card_x;
        r_y   <= i_card_y;
        r_cnt <= '0;
      end else if (r_state == StRead) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Screen coordinates are formed at 9 bits so an overhang clips instead of wrapping.
  assign w_col     = r_pix[ColW-1:0];
  assign w_row     = r_pix[AddrW-1:ColW];
  assign w_x_sum   = {1'b0, r_x} + 9'(w_col);
  assign w_y_sum   = {1'b0, r_y} + 9'(w_row);
  assign w_clip    = (w_x_sum >= 9'(ScreenW)) || (w_y_sum >= 9'(ScreenH));
  assign w_fb_addr = 16'(w_y_sum) * 16'(ScreenW) + 16'(w_x_sum);

`ifdef TRANSPARENT_EN
  assign w_skip = (i_card_data == '0);
`else
  assign w_skip = 1'b0;
`endif

  // Outputs
  always_comb begin
    o_busy      = (r_state != StIdle);
    o_done      = (r_state == StDone);
    o_card_re   = (r_state == StRead);
    o_card_addr = (r_state == StRead) ? 9'(r_cnt) : 9'd0;
    o_fb_we     = r_wr_vld && !w_clip && !w_skip;
    o_fb_addr   = r_wr_vld ? w_fb_addr : 16'd0;
    o_fb_data   = r_wr_vld ? i_card_data : '0;
  end

endmodule

// File: tb/tb_card_blitter.sv
module tb_card_blitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  card_x = 8'd0;
  logic [7:0]  card_y = 8'd0;
  logic        busy, done, card_re, fb_we;
  logic [8:0]  card_addr;
  logic [2:0]  card_data = 3'd0;
  logic [2:0]  fb_data;
  logic [15:0] fb_addr;

  always #5 clk = ~clk;

  card_blitter dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_card_x   (card_x),
    .i_card_y   (card_y),
    .o_busy     (busy),
    .o_done     (done),
    .o_card_re  (card_re),
    .o_card_addr(card_addr),
    .i_card_data(card_data),
    .o_fb_we    (fb_we),
    .o_fb_addr  (fb_addr),
    .o_fb_data  (fb_data)
  );

  // Card memory model: registered read
  logic [2:0] mem [512];
  always @(posedge clk) if (card_re) card_data <= mem[card_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  int  n_we, first_we, last_we, done_cyc, done_cnt, max_addr, t0;

  // Scoreboard: every frame buffer write must match the next expected write
  always @(negedge clk) begin
    if (mon_en) begin
      if (fb_we) begin
        if (n_we == 0) first_we = cyc;
        last_we = cyc;
        n_we++;
        if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got write addr=%0d data=%0d, required no write", fb_addr, fb_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({fb_addr, fb_data} !== {mon_e.addr, mon_e.data}) begin
            bad++;
            $display("FAIL sb_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     fb_addr, fb_data, mon_e.addr, mon_e.data);
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic clear_stats();
    n_we = 0; first_we = -1; last_we = -1; done_cyc = -1; done_cnt = 0; max_addr = -1;
    exp_q.delete();
  endtask

  task automatic fill_mod8();
    for (int i = 0; i < 512; i++) mem[i] = 3'(i % 8);
  endtask

  task automatic fill_alt();
    for (int i = 0; i < 512; i++) mem[i] = (i % 2 == 1) ? 3'd5 : 3'd0;
  endtask

  // Reference model: expected writes for a card at (x,y)
  task automatic build_exp(input int x, input int y);
    wr_t w;
    bit  wr;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 16; c++) begin
        wr = (x + c < 256) && (y + r < 240);
`ifdef TRANSPARENT_EN
        if (mem[r*16+c] == 3'd0) wr = 1'b0;
`endif
        if (wr) begin
          w.addr = 16'((y + r) * 256 + (x + c));
          w.data = mem[r*16+c];
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic start_blit(input int x, input int y);
    @(negedge clk);
    card_x = 8'(x);
    card_y = 8'(y);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int target);
    int i;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) break;
    end
    if (i == 1000) begin
      total++; bad++;
      $display("FAIL wait_done: got %0d done pulses, required %0d within 1000 cycles", done_cnt, target);
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b required 0", done); end
    total++; if (card_re !== 1'b0)   begin bad++; $display("FAIL rst_re: got %b required 0", card_re); end
    total++; if (fb_we !== 1'b0)     begin bad++; $display("FAIL rst_we: got %b required 0", fb_we); end
    total++; if (card_addr !== 9'd0) begin bad++; $display("FAIL rst_caddr: got %0d required 0", card_addr); end
    total++; if (fb_addr !== 16'd0)  begin bad++; $display("FAIL rst_faddr: got %0d required 0", fb_addr); end
    total++; if (fb_data !== 3'd0)   begin bad++; $display("FAIL rst_fdata: got %0d required 0", fb_data); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_full();
    fill_mod8();
    clear_stats();
    build_exp(0, 0);
    start_blit(0, 0);
    total++;
    if (card_re !== 1'b1 || card_addr !== 9'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL full_first_read: got re=%b addr=%0d busy=%b, required 1 0 1", card_re, card_addr, busy);
    end
    wait_done(1);
    repeat (3) @(negedge clk);
    total++; if (n_we != 512) begin bad++; $display("FAIL full_count: got %0d required 512", n_we); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_left: got %0d pending required 0", exp_q.size()); end
    total++; if (first_we - t0 + 1 != 2) begin bad++; $display("FAIL full_first_we: got k+%0d required k+2", first_we - t0 + 1); end
    total++; if (last_we - t0 + 1 != 513) begin bad++; $display("FAIL full_last_we: got k+%0d required k+513", last_we - t0 + 1); end
    total++; if (done_cyc - t0 + 1 != 514) begin bad++; $display("FAIL full_done_at: got k+%0d required k+514", done_cyc - t0 + 1); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_len: got %0d required 1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_idle: got busy=%b required 0", busy); end
  endtask

  task automatic test_clip_x();
    fill_mod8();
    clear_stats();
    build_exp(250, 0);
    start_blit(250, 0);
    wait_done(1);
    repeat (3) @(negedge clk);
    total++; if (n_we != 192) begin bad++; $display("FAIL clipx_count: got %0d required 192", n_we); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL clipx_left: got %0d pending required 0", exp_q.size()); end
    total++; if (done_cyc - t0 + 1 != 514) begin bad++; $display("FAIL clipx_done_at: got k+%0d required k+514", done_cyc - t0 + 1); end
  endtask

  task automatic test_clip_y();
    fill_mod8();
    clear_stats();
    build_exp(0, 220);
    start_blit(0, 220);
    wait_done(1);
    repeat (3) @(negedge clk);
    total++; if (n_we != 320) begin bad++; $display("FAIL clipy_count: got %0d required 320", n_we); end
    total++; if (max_addr != 61199) begin bad++; $display("FAIL clipy_max: got %0d required 61199", max_addr); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL clipy_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int i;
    int seen;
    // Second start pulse mid-blit with a new X must be ignored
    fill_mod8();
    clear_stats();
    build_exp(10, 0);
    start_blit(10, 0);
    repeat (98) @(negedge clk);
    card_x = 8'd100;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);
    total++; if (n_we != 512) begin bad++; $display("FAIL ign_count: got %0d required 512", n_we); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ign_left: got %0d pending required 0", exp_q.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done: got %0d required 1", done_cnt); end

    // Start held high: second blit begins two cycles after done
    clear_stats();
    build_exp(0, 0);
    build_exp(0, 0);
    @(negedge clk);
    card_x = 8'd0;
    card_y = 8'd0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    wait_done(1);
    seen = -1;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (card_re && card_addr == 9'd0) begin
        seen = cyc;
        break;
      end
    end
    start = 1'b0;
    total++; if (seen - t0 + 1 != 516) begin bad++; $display("FAIL held_restart: got k+%0d required k+516", seen - t0 + 1); end
    wait_done(2);
    repeat (3) @(negedge clk);
    total++; if (n_we != 1024) begin bad++; $display("FAIL held_count: got %0d required 1024", n_we); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL held_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int i;
    fill_mod8();
    clear_stats();
    build_exp(0, 0);
    start_blit(0, 0);
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (n_we >= 100) break;
    end
    rst = 1'b1;
    #1;
    total++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || card_re !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: got we=%b busy=%b re=%b required 0 0 0", fb_we, busy, card_re);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    build_exp(0, 0);
    start_blit(0, 0);
    total++;
    if (card_re !== 1'b1 || card_addr !== 9'd0) begin
      bad++;
      $display("FAIL mid_restart: got re=%b addr=%0d required 1 0", card_re, card_addr);
    end
    wait_done(1);
    repeat (3) @(negedge clk);
    total++; if (n_we != 512) begin bad++; $display("FAIL mid_count: got %0d required 512", n_we); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_transparent();
    int want;
`ifdef TRANSPARENT_EN
    want = 256;
`else
    want = 512;
`endif
    fill_alt();
    clear_stats();
    build_exp(0, 0);
    start_blit(0, 0);
    wait_done(1);
    repeat (3) @(negedge clk);
    total++; if (n_we != want) begin bad++; $display("FAIL trans_count: got %0d required %0d", n_we, want); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL trans_left: got %0d pending required 0", exp_q.size()); end
    total++; if (done_cyc - t0 + 1 != 514) begin bad++; $display("FAIL trans_done_at: got k+%0d required k+514", done_cyc - t0 + 1); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_full();
    test_clip_x();
    test_clip_y();
    test_back_to_back();
    test_reset_mid();
    test_transparent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
